// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op classification for seq_alu
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLT   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SUB   = 4'b0110,
    OP_SLTU  = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_MULHU = 4'b1001,
    OP_DIVU  = 4'b1010,
    OP_REMU  = 4'b1011,
    OP_SLL   = 4'b1100,
    OP_SRL   = 4'b1101,
    OP_SRA   = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // MUL, MULHU, DIVU and REMU all live in the 10xx code space
  function automatic logic is_multicycle(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier / restoring divider
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;

  // hi/lo: product high/low for multiply, remainder/quotient for divide
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
  end

  assign done = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      div_q <= 1'b0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      div_q <= is_div;
      b_q   <= op_b;
      hi    <= '0;
      lo    <= op_a;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
      if (div_q) begin
        // a zero divisor never restores, yielding all-ones quotient and rem = op_a
        if (!div_diff[WIDTH]) begin
          hi <= div_diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= div_sh[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with single-cycle ops and iterative mul/div
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
);

  state_e           state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic             dbz_q;
  logic             accept;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_multicycle(alu_op);
  assign shamt     = op2_q[SHAMT_W-1:0];

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (alu_op[1]),
    .op_a   (op1),
    .op_b   (op2),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_AND:   alu_res = op1_q & op2_q;
      OP_OR:    alu_res = op1_q | op2_q;
      OP_ADD:   alu_res = op1_q + op2_q;
      OP_SUB:   alu_res = op1_q - op2_q;
      OP_XOR:   alu_res = op1_q ^ op2_q;
      OP_SLT:   alu_res = WIDTH'($signed(op1_q) < $signed(op2_q));
      OP_SLTU:  alu_res = WIDTH'(op1_q < op2_q);
      OP_SLL:   alu_res = op1_q << shamt;
      OP_SRL:   alu_res = op1_q >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(op1_q) >>> shamt);
      OP_MUL,
      OP_DIVU:  alu_res = md_lo;
      OP_MULHU,
      OP_REMU:  alu_res = md_hi;
      default:  alu_res = '0;
    endcase
  end

  assign result      = out_valid ? alu_res : '0;
  assign zero        = out_valid && (alu_res == '0);
  assign div_by_zero = out_valid && dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= OP_AND;
      op1_q <= '0;
      op2_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q  <= alu_op_e'(alu_op);
            op1_q <= op1;
            op2_q <= op2;
            dbz_q <= (alu_op[3:1] == 3'b101) && (op2 == '0);
            state <= is_multicycle(alu_op) ? ST_BUSY : ST_DONE;
          end
        end
        // leaving on !md_busy as well keeps the FSM from wedging if the engine idles
        ST_BUSY: if (md_done || !md_busy) state <= ST_DONE;
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op1         (op1),
    .op2         (op2),
    .alu_op      (alu_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {32'h0, result}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("result", {32'h0, result}, {32'h0, e.res});
          chk("zero", {63'h0, zero}, {63'h0, e.z});
          chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dbz});
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic edbz, input int elat);
    int   n;
    logic busy_ok;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", {63'h0, in_ready}, 64'h1);
    e.res = er;
    e.z   = (er == 32'h0);
    e.dbz = edbz;
    exp_q.push_back(e);
    in_valid = 1'b1;
    alu_op   = op;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(elat));
    if (elat > 1) chk("in_ready_low_busy", {63'h0, busy_ok}, 64'h1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'h0);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] held;
    logic        stable;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op1       = '0;
    op2       = '0;
    alu_op    = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_result", {32'h0, result}, 64'h0);
    chk("rst_zero", {63'h0, zero}, 64'h0);
    chk("rst_dbz", {63'h0, div_by_zero}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
    issue(OP_SRA,   32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1);
    issue(OP_SRL,   32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0, 1);
    issue(OP_SLL,   32'h1,         32'h24,        32'h10,        1'b0, 1);
    issue(OP_SLT,   32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1);
    issue(OP_SLTU,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
    issue(OP_SUB,   32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1);
    issue(OP_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    issue(OP_OR,    32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1);
    issue(OP_XOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1);
    issue(4'b0101,  32'h1234,      32'h5678,      32'h0,         1'b0, 1);
    issue(4'b1111,  32'h1234,      32'h5678,      32'h0,         1'b0, 1);
    issue(OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0, 33);
    issue(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1,         1'b0, 33);
    issue(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 33);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    issue(OP_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 33);
    issue(OP_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 33);
    issue(OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 33);
    issue(OP_REMU,  32'd5,         32'd0,         32'd5,         1'b1, 33);
    drain();

    // consumer stall: output must hold and new requests must be ignored
    out_ready = 1'b0;
    issue(OP_XOR, 32'hF0F0_0000, 32'h0FF0_00FF, 32'hFF00_00FF, 1'b0, 1);
    held   = result;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      alu_op   = OP_ADD;
      op1      = 32'h1;
      op2      = 32'h1;
      @(posedge clk);
      #1;
      if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("stall_stable", {63'h0, stable}, 64'h1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("return_idle", {62'h0, out_valid, in_ready}, 64'h1);
    chk("stall_queue_empty", 64'(exp_q.size()), 64'h0);

    // reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = OP_DIVU;
    op1      = 32'd1000;
    op2      = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("div_busy", {62'h0, in_ready, out_valid}, 64'h0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'h0, out_valid}, 64'h0);
    chk("midreset_in_ready", {63'h0, in_ready}, 64'h1);
    chk("midreset_result", {32'h0, result}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    drain();
    repeat (40) @(posedge clk);
    #1;
    chk("no_stray_output", {63'h0, out_valid}, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are 8 to 64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), number of op2 LSBs used as the shift amount.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op1, op2  input  WIDTH  operands.
REQ-008 alu_op  input  4  operation code.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  high when result == 0, qualified by out_valid.
REQ-013 div_by_zero  output  1  high with out_valid when a DIVU/REMU had op2 == 0.

Function
REQ-014 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLT (signed), 0100 XOR, 0110 SUB, 0111 SLTU, 1100 SLL, 1101 SRL, 1110 SRA (signed arithmetic), 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU; all other codes produce result 0 with single-cycle latency.
REQ-015 ADD/SUB wrap modulo 2^WIDTH; SLT/SLTU give 1 or 0, zero-extended.
REQ-016 Shifts use only op2[SHAMT_W-1:0]; SRA replicates op1[WIDTH-1].
REQ-017 FSM states: IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-018 A request is accepted when in_valid && in_ready; operands and op code are registered on acceptance.
REQ-019 On acceptance of a single-cycle op, IDLE goes to DONE; out_valid rises on the next cycle (latency 1).
REQ-020 On acceptance of MUL/MULHU/DIVU/REMU, IDLE goes to BUSY; an iteration counter runs WIDTH cycles, then the FSM enters DONE (out_valid WIDTH+1 cycles after acceptance).
REQ-021 Multiplication is shift-add over 2*WIDTH bits, one bit per cycle; division is restoring, one quotient bit per cycle.
REQ-022 DIVU with op2 == 0 gives all-ones; REMU with op2 == 0 gives op1; div_by_zero = 1; latency is unchanged.
REQ-023 In DONE, result, zero and div_by_zero are held stable until out_valid && out_ready, then the FSM returns to IDLE.
REQ-024 No request is accepted in the cycle the result handshakes; the earliest next acceptance is the following cycle.
REQ-025 in_valid asserted while in BUSY or DONE is ignored; it has no side effects.
REQ-026 When out_valid is low, result and div_by_zero are 0 and zero is 0.

Reset
REQ-027 rst_n low forces state to IDLE, the counter to 0, all datapath registers to 0, out_valid to 0 and in_ready to 1, asynchronously, including mid-BUSY.
REQ-028 After rst_n deasserts, a request may be accepted on the first rising edge.

Structure
REQ-029 Op codes (as a 4-bit enum), the state enum and the is_multicycle() function reside in package alu_pkg.
REQ-030 The iterative engine is sub-module seq_muldiv, parametrised by WIDTH, with start/busy/done signals; single-cycle ops are computed in seq_alu.

Verification
REQ-031 ADD 0xFFFFFFFF + 0x1 -> result 0x0, zero 1, out_valid 1 cycle after acceptance.
REQ-032 SRA 0x80000000 by op2 0x21 (shamt 1) -> 0xC0000000; SRL with the same operands -> 0x40000000.
REQ-033 MUL 0x0001_0000 x 0x0001_0000 -> 0x0; MULHU with the same operands -> 0x1; out_valid at cycle 33; in_ready 0 during cycles 1-32.
REQ-034 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF with div_by_zero 1; REMU 5/0 -> 5.
REQ-035 out_ready held low 10 cycles in DONE -> result stable and in_valid ignored; out_ready 1 -> IDLE the next cycle.
REQ-036 rst_n pulsed low at cycle 10 of a DIVU -> out_valid 0 immediately; a fresh ADD 2+3 after reset -> 5.
